alu_arbiter: RTL



---
 rtl/alu_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU among NUM_REQ requesters. Each requester offers
// an operand/opcode transaction on a valid/ready channel. At most one is granted
// per cycle. The granted operands drive the ALU, and the result is captured with
// the requester index into a one-entry response register. The response leaves
// on a valid/ready channel.
//
// Configuration macro:
//   ALU_ARB_FIXED_PRIO_EN  defined   -> fixed priority (lowest index wins,
//                                       pointer held at 0)
//                          undefined -> round-robin starting at ptr (default)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  per-requester transaction pending
//   req_ready  per-requester accept strobe (one-hot or zero)
//   req_a      packed operand a, requester i at [i*DATA_W +: DATA_W]
//   req_b      packed operand b, same packing
//   req_op     packed opcode,   requester i at [i*OP_W +: OP_W]
//   alu_a      operand a to the ALU (zero when nothing is granted)
//   alu_b      operand b to the ALU (zero when nothing is granted)
//   alu_op     opcode to the ALU    (zero when nothing is granted)
//   alu_out    ALU result
//   alu_c      ALU carry
//   rsp_valid  response register holds a result
//   rsp_ready  consumer accepts the response
//   rsp_out    registered result
//   rsp_c      registered carry
//   rsp_id     index of the requester that produced the response
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int OP_W    = 3,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   input  logic [NUM_REQ*OP_W-1:0]   req_op,
   output logic [DATA_W-1:0]         alu_a,
   output logic [DATA_W-1:0]         alu_b,
   output logic [OP_W-1:0]           alu_op,
   input  logic [DATA_W-1:0]         alu_out,
   input  logic                      alu_c,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_W-1:0]         rsp_out,
   output logic                      rsp_c,
   output logic [ID_W-1:0]           rsp_id
);

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [ID_W-1:0]     ptr;
   logic [ID_W-1:0]     ptr_next;
   logic                issue_en;
   logic [NUM_REQ-1:0]  hi_req;
   logic [NUM_REQ-1:0]  cand;
   logic [NUM_REQ-1:0]  grant_vec;
   logic [ID_W-1:0]     grant_idx;
   logic                grant_any;

   // Issue is possible when the response slot is empty or is being drained now.
   always_comb begin
      issue_en = 1'b0;
      if (rst) begin
         issue_en = 1'b0;
      end else if (state == EMPTY) begin
         issue_en = 1'b1;
      end else if (rsp_ready) begin
         issue_en = 1'b1;
      end else begin
         issue_en = 1'b0;
      end
   end

   // Requests at or above the pointer; these win over the wrapped-around ones.
   always_comb begin
      hi_req = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (i >= int'(ptr)) begin
            hi_req[i] = req_valid[i];
         end else begin
            hi_req[i] = 1'b0;
         end
      end
   end

   // Circular search from ptr: lowest set bit of the upper half if any,
   // otherwise lowest set bit overall (the wrap). Isolating the lowest set bit
   // gives the one-hot grant directly.
   always_comb begin
      cand      = (|hi_req) ? hi_req : req_valid;
      grant_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         grant_idx = cand[i] ? ID_W'(i) : grant_idx;
      end
      grant_any = issue_en & (|req_valid);
      if (grant_any) begin
         grant_vec = cand & (~cand + NUM_REQ'(1));
      end else begin
         grant_vec = '0;
      end
   end

   assign req_ready = grant_vec;

   // Operand mux; the grant is one-hot or zero, so an AND-OR mux is exact and
   // yields zero when nothing is granted.
   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         alu_a  = alu_a  | ({DATA_W{grant_vec[i]}} & req_a[i*DATA_W +: DATA_W]);
         alu_b  = alu_b  | ({DATA_W{grant_vec[i]}} & req_b[i*DATA_W +: DATA_W]);
         alu_op = alu_op | ({OP_W{grant_vec[i]}}   & req_op[i*OP_W +: OP_W]);
      end
   end

   // Pointer advance target after a grant to grant_idx.
   always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      // Fixed priority: search always starts at requester 0.
      ptr_next = '0;
`else
      if (grant_idx == ID_W'(NUM_REQ - 1)) begin
         ptr_next = '0;
      end else begin
         ptr_next = grant_idx + ID_W'(1);
      end
`endif
   end

   // Response-slot next state: a grant always fills; a drain without grant empties.
   always_comb begin
      state_next = state;
      case (state)
         EMPTY: begin
            if (grant_any) begin
               state_next = FULL;
            end else begin
               state_next = EMPTY;
            end
         end
         FULL: begin
            if (grant_any) begin
               state_next = FULL;
            end else if (rsp_ready) begin
               state_next = EMPTY;
            end else begin
               state_next = FULL;
            end
         end
         default: begin
            state_next = EMPTY;
         end
      endcase
   end

   // State, pointer and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= EMPTY;
         ptr     <= '0;
         rsp_out <= '0;
         rsp_c   <= 1'b0;
         rsp_id  <= '0;
      end else begin
         state <= state_next;
         if (grant_any) begin
            rsp_out <= alu_out;
            rsp_c   <= alu_c;
            rsp_id  <= grant_idx;
            ptr     <= ptr_next;
         end else begin
            rsp_out <= rsp_out;
            rsp_c   <= rsp_c;
            rsp_id  <= rsp_id;
            ptr     <= ptr;
         end
      end
   end

   assign rsp_valid = (state == FULL);

endmodule
